// File: rtl/bm_pkg.sv
// rtl/bm_pkg.sv - shared AHB encodings, FSM state and address/control bundle for the bus matrix
// Contents:
//   HTRANS_*  transfer type encodings (IDLE/BUSY/NONSEQ/SEQ)
//   HRESP_*   response encodings (OKAY/ERROR)
//   HBURST_*  burst encodings used by the input stage (SINGLE/INCR)
//   bm_in_state_e   input stage FSM state (PASS/HOLD)
//   bm_addr_ctrl_t  address-phase signals captured by the hold register
package bm_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_HOLD = 1'b1
  } bm_in_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        mastlock;
  } bm_addr_ctrl_t;

  // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY never carry a transfer.
  function automatic logic is_active_trans(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/bm_in_stage_holdreg.sv
// rtl/bm_in_stage_holdreg.sv - hold register for a refused address phase, with optional burst remap
// Ports:
//   HCLK, HRESETn  clock, asynchronous active-low reset
//   capture_i      load ctrl_i into the hold register this cycle
//   ctrl_i         master address/control to capture
//   ctrl_o         held address/control as presented to the decoder
// Build option: BM_IN_STAGE_SEQ_TO_NSEQ_EN turns a held SEQ into NONSEQ and any held
// fixed/wrapping burst into INCR, since the refusal has already broken the burst.
import bm_pkg::*;

module bm_in_stage_holdreg (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          capture_i,
  input  bm_addr_ctrl_t ctrl_i,
  output bm_addr_ctrl_t ctrl_o
);

  bm_addr_ctrl_t hold_q;
  bm_addr_ctrl_t hold_d;

  always_comb begin
    hold_d = hold_q;
    if (capture_i) hold_d = ctrl_i;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) hold_q <= '0;
    else          hold_q <= hold_d;
  end

`ifdef BM_IN_STAGE_SEQ_TO_NSEQ_EN
  always_comb begin
    ctrl_o = hold_q;
    if (hold_q.trans == HTRANS_SEQ) ctrl_o.trans = HTRANS_NONSEQ;
    if ((hold_q.trans == HTRANS_SEQ) || (hold_q.burst != HBURST_SINGLE))
      ctrl_o.burst = HBURST_INCR;
  end
`else
  assign ctrl_o = hold_q;
`endif

endmodule

// File: rtl/bm_input_stage.sv
// rtl/bm_input_stage.sv - per-master AHB bus matrix input stage: holds refused transfers, routes data-phase response
// Ports:
//   HCLK, HRESETn                   clock, asynchronous active-low reset
//   HSELS..HMASTLOCKS, HREADYS      master-side address phase and bus HREADY
//   addr_in_phase, data_in_phase    arbitration status from the output stages
//   HREADYM, HRESPM                 ready/response of the output serving this port
//   HSELM..HMASTLOCKM               address phase presented to the decoder
//   HREADYOUTS, HRESPS              ready/response returned to the master
// Build option: BM_IN_STAGE_SEQ_TO_NSEQ_EN (see bm_in_stage_holdreg).
import bm_pkg::*;

module bm_input_stage (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic [2:0]  HBURSTS,
  input  logic [3:0]  HPROTS,
  input  logic        HMASTLOCKS,
  input  logic        HREADYS,
  input  logic        addr_in_phase,
  input  logic        data_in_phase,
  input  logic        HREADYM,
  input  logic        HRESPM,
  output logic        HSELM,
  output logic [31:0] HADDRM,
  output logic [1:0]  HTRANSM,
  output logic        HWRITEM,
  output logic [2:0]  HSIZEM,
  output logic [2:0]  HBURSTM,
  output logic [3:0]  HPROTM,
  output logic        HMASTLOCKM,
  output logic        HREADYOUTS,
  output logic        HRESPS
);

  bm_in_state_e  state_q, state_d;
  logic          dphase_q, dphase_d;
  logic          new_trans, accept, capture, dphase_set;
  bm_addr_ctrl_t master_ctrl, held_ctrl, out_ctrl;

  assign master_ctrl = '{addr: HADDRS, trans: HTRANSS, write: HWRITES, size: HSIZES,
                         burst: HBURSTS, prot: HPROTS, mastlock: HMASTLOCKS};

  assign new_trans  = HSELS & HREADYS & is_active_trans(HTRANSS);
  assign accept     = addr_in_phase & HREADYM;
  assign capture    = (state_q == ST_PASS) & new_trans & ~accept;
  assign dphase_set = ((state_q == ST_PASS) & new_trans & accept) | ((state_q == ST_HOLD) & accept);

  bm_in_stage_holdreg u_holdreg (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .capture_i (capture),
    .ctrl_i    (master_ctrl),
    .ctrl_o    (held_ctrl)
  );

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_PASS;
      dphase_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dphase_q <= dphase_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PASS: if (capture) state_d = ST_HOLD;
      ST_HOLD: if (accept)  state_d = ST_PASS;
      default: state_d = ST_PASS;
    endcase
  end

  // A new accept wins over the end of the previous data phase, so back-to-back
  // transfers keep dphase high without a bubble.
  always_comb begin
    dphase_d = dphase_q;
    if (dphase_set)                      dphase_d = 1'b1;
    else if (data_in_phase & HREADYM)    dphase_d = 1'b0;
  end

  // Outputs
  always_comb begin
    out_ctrl   = master_ctrl;
    HSELM      = HSELS;
    HREADYOUTS = 1'b1;
    if (state_q == ST_HOLD) begin
      out_ctrl   = held_ctrl;
      HSELM      = 1'b1;
      HREADYOUTS = 1'b0;
    end else if (dphase_q) begin
      HREADYOUTS = data_in_phase ? HREADYM : 1'b0;
    end
    HRESPS = (dphase_q & data_in_phase) ? HRESPM : HRESP_OKAY;
  end

  assign HADDRM     = out_ctrl.addr;
  assign HTRANSM    = out_ctrl.trans;
  assign HWRITEM    = out_ctrl.write;
  assign HSIZEM     = out_ctrl.size;
  assign HBURSTM    = out_ctrl.burst;
  assign HPROTM     = out_ctrl.prot;
  assign HMASTLOCKM = out_ctrl.mastlock;

endmodule

// File: tb/tb_bm_input_stage.sv
// tb/tb_bm_input_stage.sv - self-checking bench for bm_input_stage with an accepted-transfer scoreboard
module tb_bm_input_stage;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000, B_INCR = 3'b001, B_INCR4 = 3'b011;
`ifdef BM_IN_STAGE_SEQ_TO_NSEQ_EN
  localparam bit REMAP = 1'b1;
`else
  localparam bit REMAP = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HMASTLOCKS;
  wire         HREADYS;
  logic        addr_in_phase, data_in_phase, HREADYM, HRESPM;
  logic        HSELM;
  logic [31:0] HADDRM;
  logic [1:0]  HTRANSM;
  logic        HWRITEM;
  logic [2:0]  HSIZEM, HBURSTM;
  logic [3:0]  HPROTM;
  logic        HMASTLOCKM, HREADYOUTS, HRESPS;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic        write;
  } xfer_t;
  xfer_t exp_q[$];

  always #5 HCLK = ~HCLK;

  // HREADYOUTS is looped back to the master side as on the real port.
  assign HREADYS = HREADYOUTS;

  bm_input_stage dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS), .HWRITES(HWRITES),
    .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS),
    .HREADYS(HREADYS), .addr_in_phase(addr_in_phase), .data_in_phase(data_in_phase),
    .HREADYM(HREADYM), .HRESPM(HRESPM),
    .HSELM(HSELM), .HADDRM(HADDRM), .HTRANSM(HTRANSM), .HWRITEM(HWRITEM),
    .HSIZEM(HSIZEM), .HBURSTM(HBURSTM), .HPROTM(HPROTM), .HMASTLOCKM(HMASTLOCKM),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
  );

  // Scoreboard: every accepted address phase must match the oldest expected transfer.
  always @(negedge HCLK) begin
    if (HRESETn && HSELM && HTRANSM[1] && addr_in_phase && HREADYM) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got addr %h trans %b, scoreboard empty", HADDRM, HTRANSM);
      end else begin
        xfer_t e;
        e = exp_q.pop_front();
        if ({HADDRM, HTRANSM, HBURSTM, HWRITEM} !== {e.addr, e.trans, e.burst, e.write}) begin
          n_err++;
          $display("FAIL sb_xfer: got addr %h trans %b burst %b wr %b, want addr %h trans %b burst %b wr %b",
                   HADDRM, HTRANSM, HBURSTM, HWRITEM, e.addr, e.trans, e.burst, e.write);
        end
      end
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                       input logic wr, input logic [2:0] bu);
    HSELS = sel; HTRANSS = tr; HADDRS = a; HWRITES = wr; HBURSTS = bu;
    HSIZES = 3'b010; HPROTS = 4'b0011; HMASTLOCKS = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic [1:0] tr, input logic [2:0] bu, input logic wr);
    xfer_t e;
    e.addr = a; e.trans = tr; e.burst = bu; e.write = wr;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    drive(1'b1, T_NSEQ, 32'h1234_5678, 1'b0, B_SINGLE);
    addr_in_phase = 1'b0; data_in_phase = 1'b1; HREADYM = 1'b0; HRESPM = 1'b1;
    #2;
    n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL reset_hreadyout: got %b want 1", HREADYOUTS); end
    n_cmp++; if (HRESPS !== 1'b0) begin n_err++; $display("FAIL reset_hresp: got %b want 0", HRESPS); end
    n_cmp++; if (HTRANSM !== T_NSEQ) begin n_err++; $display("FAIL reset_htrans: got %b want %b", HTRANSM, T_NSEQ); end
    n_cmp++; if (HSELM !== 1'b1) begin n_err++; $display("FAIL reset_hsel: got %b want 1", HSELM); end
    n_cmp++; if (HADDRM !== 32'h1234_5678) begin n_err++; $display("FAIL reset_haddr: got %h want 12345678", HADDRM); end
    tick();
    HRESETn = 1'b1;
    drive(1'b0, T_IDLE, 32'h0, 1'b0, B_SINGLE);
    data_in_phase = 1'b0; HREADYM = 1'b1; HRESPM = 1'b0;
    tick();
  endtask

  task automatic test_pass();
    drive(1'b1, T_NSEQ, 32'h2000_0000, 1'b0, B_SINGLE);
    addr_in_phase = 1'b1; HREADYM = 1'b1; data_in_phase = 1'b0;
    push(32'h2000_0000, T_NSEQ, B_SINGLE, 1'b0);
    #2;
    n_cmp++; if (HTRANSM !== T_NSEQ) begin n_err++; $display("FAIL pass_htrans: got %b want %b", HTRANSM, T_NSEQ); end
    n_cmp++; if (HADDRM !== 32'h2000_0000) begin n_err++; $display("FAIL pass_haddr: got %h want 20000000", HADDRM); end
    n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL pass_hready: got %b want 1", HREADYOUTS); end
    tick();
    drive(1'b0, T_IDLE, 32'h0, 1'b0, B_SINGLE);
    addr_in_phase = 1'b0; data_in_phase = 1'b1; HREADYM = 1'b0;
    #2;
    n_cmp++; if (HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL pass_dphase_wait: got %b want 0", HREADYOUTS); end
    HREADYM = 1'b1;
    #1;
    n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL pass_dphase_ready: got %b want 1", HREADYOUTS); end
    tick();
    data_in_phase = 1'b0;
    #2;
    n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL pass_dphase_done: got %b want 1", HREADYOUTS); end
    tick();
  endtask

  task automatic test_hold();
    drive(1'b1, T_NSEQ, 32'h4000_0010, 1'b1, B_SINGLE);
    addr_in_phase = 1'b0; HREADYM = 1'b1; data_in_phase = 1'b0;
    push(32'h4000_0010, T_NSEQ, B_SINGLE, 1'b1);
    #2;
    n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL hold_capture_ready: got %b want 1", HREADYOUTS); end
    tick();
    drive(1'b1, T_NSEQ, 32'hDEAD_0000, 1'b0, B_SINGLE);
    #2;
    n_cmp++; if (HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL hold_stall1: got %b want 0", HREADYOUTS); end
    n_cmp++; if (HADDRM !== 32'h4000_0010) begin n_err++; $display("FAIL hold_addr1: got %h want 40000010", HADDRM); end
    n_cmp++; if (HWRITEM !== 1'b1) begin n_err++; $display("FAIL hold_write: got %b want 1", HWRITEM); end
    tick();
    drive(1'b0, T_IDLE, 32'hBEEF_0000, 1'b0, B_SINGLE);
    #2;
    n_cmp++; if (HSELM !== 1'b1) begin n_err++; $display("FAIL hold_hsel: got %b want 1", HSELM); end
    n_cmp++; if (HTRANSM !== T_NSEQ) begin n_err++; $display("FAIL hold_htrans: got %b want %b", HTRANSM, T_NSEQ); end
    n_cmp++; if (HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL hold_stall2: got %b want 0", HREADYOUTS); end
    tick();
    addr_in_phase = 1'b1;
    #2;
    n_cmp++; if (HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL hold_accept_ready: got %b want 0", HREADYOUTS); end
    n_cmp++; if (HADDRM !== 32'h4000_0010) begin n_err++; $display("FAIL hold_addr_accept: got %h want 40000010", HADDRM); end
    tick();
    drive(1'b0, T_IDLE, 32'h0, 1'b0, B_SINGLE);
    addr_in_phase = 1'b0; data_in_phase = 1'b1; HREADYM = 1'b1;
    #2;
    n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL hold_back_pass: got %b want 1", HREADYOUTS); end
    n_cmp++; if (HADDRM !== 32'h0) begin n_err++; $display("FAIL hold_pass_mirror: got %h want 0", HADDRM); end
    tick();
    data_in_phase = 1'b0;
    tick();
  endtask

  task automatic test_seq_remap();
    logic [1:0] exp_tr;
    logic [2:0] exp_bu;
    exp_tr = REMAP ? T_NSEQ : T_SEQ;
    exp_bu = REMAP ? B_INCR : B_INCR4;
    drive(1'b1, T_NSEQ, 32'h100, 1'b1, B_INCR4);
    addr_in_phase = 1'b1; HREADYM = 1'b1; data_in_phase = 1'b0;
    push(32'h100, T_NSEQ, B_INCR4, 1'b1);
    tick();
    drive(1'b1, T_SEQ, 32'h104, 1'b1, B_INCR4);
    data_in_phase = 1'b1;
    push(32'h104, T_SEQ, B_INCR4, 1'b1);
    #2;
    n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL seq_beat2_ready: got %b want 1", HREADYOUTS); end
    tick();
    drive(1'b1, T_SEQ, 32'h108, 1'b1, B_INCR4);
    addr_in_phase = 1'b0;
    push(32'h108, exp_tr, exp_bu, 1'b1);
    #2;
    n_cmp++; if (HTRANSM !== T_SEQ) begin n_err++; $display("FAIL seq_pass_nomap_trans: got %b want %b", HTRANSM, T_SEQ); end
    n_cmp++; if (HBURSTM !== B_INCR4) begin n_err++; $display("FAIL seq_pass_nomap_burst: got %b want %b", HBURSTM, B_INCR4); end
    tick();
    data_in_phase = 1'b0;
    #2;
    n_cmp++; if (HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL seq_hold_ready: got %b want 0", HREADYOUTS); end
    n_cmp++; if (HTRANSM !== exp_tr) begin n_err++; $display("FAIL seq_hold_trans: got %b want %b", HTRANSM, exp_tr); end
    n_cmp++; if (HBURSTM !== exp_bu) begin n_err++; $display("FAIL seq_hold_burst: got %b want %b", HBURSTM, exp_bu); end
    n_cmp++; if (HADDRM !== 32'h108) begin n_err++; $display("FAIL seq_hold_addr: got %h want 108", HADDRM); end
    tick();
    addr_in_phase = 1'b1;
    #2;
    n_cmp++; if (HTRANSM !== exp_tr) begin n_err++; $display("FAIL seq_accept_trans: got %b want %b", HTRANSM, exp_tr); end
    tick();
    drive(1'b0, T_IDLE, 32'h0, 1'b0, B_SINGLE);
    addr_in_phase = 1'b0; data_in_phase = 1'b1;
    tick();
    data_in_phase = 1'b0;
    tick();
  endtask

  task automatic test_error();
    drive(1'b1, T_NSEQ, 32'h3000, 1'b0, B_SINGLE);
    addr_in_phase = 1'b1; HREADYM = 1'b1; data_in_phase = 1'b0;
    push(32'h3000, T_NSEQ, B_SINGLE, 1'b0);
    tick();
    drive(1'b0, T_IDLE, 32'h0, 1'b0, B_SINGLE);
    addr_in_phase = 1'b0; data_in_phase = 1'b1; HREADYM = 1'b0; HRESPM = 1'b1;
    #2;
    n_cmp++; if (HRESPS !== 1'b1) begin n_err++; $display("FAIL err_resp1: got %b want 1", HRESPS); end
    n_cmp++; if (HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL err_ready1: got %b want 0", HREADYOUTS); end
    tick();
    HREADYM = 1'b1;
    #2;
    n_cmp++; if (HRESPS !== 1'b1) begin n_err++; $display("FAIL err_resp2: got %b want 1", HRESPS); end
    n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL err_ready2: got %b want 1", HREADYOUTS); end
    tick();
    data_in_phase = 1'b0;
    #2;
    n_cmp++; if (HRESPS !== 1'b0) begin n_err++; $display("FAIL err_resp_after: got %b want 0", HRESPS); end
    tick();
    HRESPM = 1'b0;
  endtask

  task automatic test_idle_busy();
    drive(1'b1, T_BUSY, 32'h7000, 1'b0, B_SINGLE);
    addr_in_phase = 1'b0; HREADYM = 1'b1; data_in_phase = 1'b0;
    #2;
    n_cmp++; if (HTRANSM !== T_BUSY) begin n_err++; $display("FAIL busy_mirror: got %b want %b", HTRANSM, T_BUSY); end
    tick();
    drive(1'b1, T_IDLE, 32'h7004, 1'b0, B_SINGLE);
    #2;
    n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL busy_not_held: got %b want 1", HREADYOUTS); end
    n_cmp++; if (HADDRM !== 32'h7004) begin n_err++; $display("FAIL idle_mirror_addr: got %h want 7004", HADDRM); end
    tick();
    drive(1'b0, T_NSEQ, 32'h7008, 1'b0, B_SINGLE);
    tick();
    drive(1'b0, T_IDLE, 32'h0, 1'b0, B_SINGLE);
    #2;
    n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL unsel_not_held: got %b want 1", HREADYOUTS); end
    n_cmp++; if (HSELM !== 1'b0) begin n_err++; $display("FAIL unsel_hsel: got %b want 0", HSELM); end
    tick();
  endtask

  task automatic test_reset_hold();
    // The transfer captured here is dropped by reset, so it is not expected downstream.
    drive(1'b1, T_NSEQ, 32'h5000, 1'b1, B_SINGLE);
    addr_in_phase = 1'b0; HREADYM = 1'b1; data_in_phase = 1'b0;
    tick();
    drive(1'b0, T_IDLE, 32'h0, 1'b0, B_SINGLE);
    #2;
    n_cmp++; if (HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL rsthold_stall: got %b want 0", HREADYOUTS); end
    HRESETn = 1'b0;
    #1;
    n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL rsthold_ready: got %b want 1", HREADYOUTS); end
    n_cmp++; if (HTRANSM !== T_IDLE) begin n_err++; $display("FAIL rsthold_trans: got %b want %b", HTRANSM, T_IDLE); end
    n_cmp++; if (HSELM !== 1'b0) begin n_err++; $display("FAIL rsthold_hsel: got %b want 0", HSELM); end
    tick();
    HRESETn = 1'b1;
    #2;
    n_cmp++; if (HTRANSM !== T_IDLE) begin n_err++; $display("FAIL rsthold_after_trans: got %b want %b", HTRANSM, T_IDLE); end
    n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL rsthold_after_ready: got %b want 1", HREADYOUTS); end
    tick();
    drive(1'b1, T_NSEQ, 32'h5000, 1'b1, B_SINGLE);
    addr_in_phase = 1'b1;
    push(32'h5000, T_NSEQ, B_SINGLE, 1'b1);
    #2;
    n_cmp++; if (HADDRM !== 32'h5000) begin n_err++; $display("FAIL rsthold_reissue: got %h want 5000", HADDRM); end
    tick();
    drive(1'b0, T_IDLE, 32'h0, 1'b0, B_SINGLE);
    addr_in_phase = 1'b0; data_in_phase = 1'b1;
    tick();
    data_in_phase = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, T_NSEQ, 32'h6000, 1'b0, B_SINGLE);
    addr_in_phase = 1'b1; HREADYM = 1'b1; data_in_phase = 1'b0;
    push(32'h6000, T_NSEQ, B_SINGLE, 1'b0);
    tick();
    drive(1'b1, T_NSEQ, 32'h6004, 1'b0, B_SINGLE);
    data_in_phase = 1'b1;
    push(32'h6004, T_NSEQ, B_SINGLE, 1'b0);
    #2;
    n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b want 1", HREADYOUTS); end
    tick();
    drive(1'b0, T_IDLE, 32'h0, 1'b0, B_SINGLE);
    addr_in_phase = 1'b0; HREADYM = 1'b0;
    #2;
    n_cmp++; if (HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL b2b_dphase_kept: got %b want 0", HREADYOUTS); end
    tick();
    HREADYM = 1'b1;
    #2;
    n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL b2b_second_done: got %b want 1", HREADYOUTS); end
    tick();
    data_in_phase = 1'b0;
    #2;
    n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL b2b_idle: got %b want 1", HREADYOUTS); end
    tick();
  endtask

  initial begin
    test_reset();
    test_pass();
    test_hold();
    test_seq_remap();
    test_error();
    test_idle_busy();
    test_reset_hold();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d pending transfers want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
